// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate from a 50 MHz clock.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 16;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus sync/visible decode of the position
// it will hold after this clock, so the caller can register them in lockstep.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FP     = DEF_H_FP,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter int   BP     = DEF_H_BP,
    parameter logic POL    = POL_LOW,
    parameter int   CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          sync,
    output logic          vis
);

    localparam int            TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] VIS_END    = CW'(ACTIVE);

    generate
        if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
            $error("vga_axis_counter: every timing parameter must be non-zero");
        end
    endgenerate

    logic [CW-1:0] count_next;
    logic          in_sync;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        wrap       = step && (count == LAST);
        count_next = count;
        if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
        in_sync = (count_next >= SYNC_START) && (count_next < SYNC_END);
        sync    = in_sync ? POL : ~POL;
        vis     = count_next < VIS_END;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y axis counters and
// registered sync, active, line-end and frame-start outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = POL_LOW,
    parameter logic VS_POL   = POL_LOW,
    parameter int   CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [CW-1:0] x_c,
    output logic [CW-1:0] y_c,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_end,
    output logic          frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (CW < 1 || CW > 31 || ((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
            $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    logic [DW-1:0] div;
    logic          tick;
    logic          x_wrap, y_wrap, h_sync, v_sync, h_vis, v_vis;

    // tick is the clock in which the raster advances one pixel
    assign tick = en && (div == DW'(CLK_DIV - 1));

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HS_POL), .CW (CW)
    ) u_x (
        .clk (clk), .rst (rst), .step (tick),
        .count (x_c), .wrap (x_wrap), .sync (h_sync), .vis (h_vis)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VS_POL), .CW (CW)
    ) u_y (
        .clk (clk), .rst (rst), .step (x_wrap),
        .count (y_c), .wrap (y_wrap), .sync (v_sync), .vis (v_vis)
    );

    // Decodes come from the axis next-state, so they land with the counts they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            active      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
        end else begin
            if (en) begin
                div <= tick ? '0 : div + 1'b1;
            end
            pix_ce      <= tick;
            line_end    <= x_wrap;
            frame_start <= x_wrap & y_wrap;
            active      <= h_vis & v_vis;
            hsync       <= h_sync;
            vsync       <= v_sync;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance and a tiny overridden instance
// share one rst/en stream; a position-arithmetic model predicts every clock.
module tb_vga_timing_gen;

    typedef struct {
        int cd, ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic        pce;
        logic [15:0] x;
        logic [15:0] y;
        logic        hs, vs, act, le, fs;
    } exp_t;

    localparam cfg_t CFG_DEF   = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam cfg_t CFG_SMALL = '{1, 8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic        d_pce, d_hs, d_vs, d_act, d_le, d_fs;
    logic [15:0] d_x, d_y;
    logic        s_pce, s_hs, s_vs, s_act, s_le, s_fs;
    logic [15:0] s_x, s_y;

    int total = 0;
    int bad   = 0;

    exp_t q_def[$];
    exp_t q_small[$];

    // model state: enabled clocks since reset, and what the last edge did
    int n_en      = 0;
    bit last_rst  = 1'b1;
    bit last_en   = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk (clk), .rst (rst), .en (en),
        .pix_ce (d_pce), .x_c (d_x), .y_c (d_y), .hsync (d_hs), .vsync (d_vs),
        .active (d_act), .line_end (d_le), .frame_start (d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .CW (16)
    ) dut_small (
        .clk (clk), .rst (rst), .en (en),
        .pix_ce (s_pce), .x_c (s_x), .y_c (s_y), .hsync (s_hs), .vsync (s_vs),
        .active (s_act), .line_end (s_le), .frame_start (s_fs)
    );

    // Raster position is simply (enabled clocks / CLK_DIV) folded onto the frame.
    function automatic exp_t model(input cfg_t c, input int n, input bit lr, input bit le_);
        exp_t e;
        int   ht, vt, p, x, y;
        e    = '0;
        e.hs = ~c.hp;
        e.vs = ~c.vp;
        if (lr) return e;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        p     = n / c.cd;
        x     = p % ht;
        y     = (p / ht) % vt;
        e.pce = le_ && (n > 0) && ((n % c.cd) == 0);
        e.x   = 16'(x);
        e.y   = 16'(y);
        e.hs  = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
        e.vs  = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
        e.act = (x < c.ha) && (y < c.va);
        e.le  = e.pce && (x == 0);
        e.fs  = e.le && (y == 0);
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("pce=%0b x=%0d y=%0d hs=%0b vs=%0b act=%0b le=%0b fs=%0b",
                         e.pce, e.x, e.y, e.hs, e.vs, e.act, e.le, e.fs);
    endfunction

    task automatic check(input string name, input string got, input string want, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, predict, return at the negedge.
    task automatic cyc(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            n_en     = 0;
            last_rst = 1'b1;
            last_en  = 1'b0;
        end else begin
            last_rst = 1'b0;
            last_en  = e;
            if (e) n_en++;
        end
        q_def.push_back(model(CFG_DEF, n_en, last_rst, last_en));
        q_small.push_back(model(CFG_SMALL, n_en, last_rst, last_en));
        @(negedge clk);
    endtask

    // Clocks between two consecutive pulses with en held high; bounded.
    task automatic measure(input bit use_small, input int want, input string name);
        int first = -1;
        int got   = -1;
        for (int i = 0; i < 3 * want + 10 && got < 0; i++) begin
            cyc(1'b0, 1'b1);
            if (use_small ? s_fs : d_le) begin
                if (first < 0) first = i;
                else           got   = i - first;
            end
        end
        check(name, $sformatf("%0d", got), $sformatf("%0d", want), got == want);
    endtask

    // Monitor: one expected tuple per clock per instance.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (q_def.size() > 0) begin
                e = q_def.pop_front();
                g = '{d_pce, d_x, d_y, d_hs, d_vs, d_act, d_le, d_fs};
                check("def_raster", fmt(g), fmt(e), g === e);
            end
            if (q_small.size() > 0) begin
                e = q_small.pop_front();
                g = '{s_pce, s_x, s_y, s_hs, s_vs, s_act, s_le, s_fs};
                check("small_raster", fmt(g), fmt(e), g === e);
            end
        end
    end

    initial begin
        repeat (3) cyc(1'b1, 1'b0);
        repeat (600) cyc(1'b0, 1'b1);       // default raster at x_c=300
        repeat (3) cyc(1'b1, 1'b1);         // abort mid-frame
        repeat (600) cyc(1'b0, 1'b1);
        repeat (100) cyc(1'b0, 1'b0);       // freeze at x_c=300
        repeat (50) cyc(1'b0, 1'b1);
        measure(1'b0, 1600, "line_end_period");
        measure(1'b1, 98, "frame_start_period");
        measure(1'b1, 98, "frame_start_period2");
        for (int i = 0; i < 15000; i++) begin
            cyc(($urandom_range(0, 2999) == 0), ($urandom_range(0, 7) != 0));
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
